// File: rtl/servo_pkg.sv
// servo_pkg: constants and FSM state type shared by the servo PWM generator and decoder
package servo_pkg;
    localparam int POS_W      = 8;
    localparam int TICK_W     = 10;
    localparam int PULSE_BASE = 256;
    localparam int PULSE_MAX  = 511;
    localparam int TICK_SAT   = 512;
    localparam int DEF_DIV    = 47;
    typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, MEASURE, WAIT_FALL} dec_state_t;
endpackage

// File: rtl/servo_sync.sv
// servo_sync: 2-flop synchronizer with rise/fall detect for an asynchronous pin
//   clk, rst   system clock, async active-high reset (pipeline resets low)
//   din        asynchronous pin input
//   level      synchronized level (q2)
//   rise/fall  one-cycle edge strobes from q2 vs. q3
module servo_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic q1, q2, q3;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q1, q2, q3} <= '0;
        else {q1, q2, q3} <= {din, q1, q2};
    assign level = q2;
    assign rise  = q2 & ~q3;
    assign fall  = ~q2 & q3;
endmodule

// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder: measures servo pulse high time and recovers the 8-bit position
//   DIV/TIMEOUT  system clocks per tick (>= 4) / idle ticks before signal_lost
//   clk, rst     system clock, async active-high reset
//   pwm_in       asynchronous servo pulse input
//   pos          last valid position (high time = 256 + pos ticks)
//   pos_valid    one-cycle strobe on pos update
//   pos_err      one-cycle strobe on out-of-range pulse
//   signal_lost  no rising edge for TIMEOUT ticks; only with SERVO_DEC_TIMEOUT_EN, else 0
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int DIV     = DEF_DIV,
    parameter int TIMEOUT = 8192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [POS_W-1:0] pos,
    output logic             pos_valid,
    output logic             pos_err,
    output logic             signal_lost
);
    localparam int SUB_W = $clog2(DIV);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(DIV - 1);
    localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(DIV / 2);

    logic level, rise, fall;
    servo_sync u_sync (.clk(clk), .rst(rst), .din(pwm_in), .level(level), .rise(rise), .fall(fall));

    logic [SUB_W-1:0]  sub;
    logic [TICK_W-1:0] ticks;
    logic tick_wrap, tick_full;
    assign tick_wrap = sub == SUB_LAST;
    assign tick_full = ticks == TICK_W'(TICK_SAT);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sub   <= '0;
            ticks <= '0;
        end else if (rise) begin
            sub   <= '0;
            ticks <= '0;
        end else begin
            sub   <= tick_wrap ? '0 : sub + SUB_W'(1);
            ticks <= (tick_wrap && !tick_full) ? ticks + TICK_W'(1) : ticks;
        end

    // The synchronizer powers up low, so its output is not a real pin sample
    // until two edges after reset; WAIT_LOW must not trust it before then.
    logic [1:0] warm;
    logic primed;
    assign primed = warm[1];

    dec_state_t state, state_nx;
    logic [TICK_W-1:0] width;
    logic in_range, valid_nx, err_nx;

    always_comb begin
        width    = ticks + TICK_W'(sub >= SUB_HALF);
        in_range = width >= TICK_W'(PULSE_BASE) && width <= TICK_W'(PULSE_MAX);
        state_nx = state;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        case (state)
            WAIT_LOW:  state_nx = (primed && !level) ? WAIT_RISE : WAIT_LOW;
            WAIT_RISE: state_nx = rise ? MEASURE : WAIT_RISE;
            MEASURE:
                if (fall) begin
                    state_nx = WAIT_RISE;
                    valid_nx = in_range;
                    err_nx   = !in_range;
                end else if (tick_full) begin
                    state_nx = WAIT_FALL;
                    err_nx   = 1'b1;
                end
            WAIT_FALL: state_nx = fall ? WAIT_RISE : WAIT_FALL;
            default:   state_nx = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            warm      <= '0;
            state     <= WAIT_LOW;
            pos       <= '0;
            pos_valid <= 1'b0;
            pos_err   <= 1'b0;
        end else begin
            warm      <= {warm[0], 1'b1};
            state     <= state_nx;
            pos       <= valid_nx ? POS_W'(width - TICK_W'(PULSE_BASE)) : pos;
            pos_valid <= valid_nx;
            pos_err   <= err_nx;
        end

`ifdef SERVO_DEC_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle;
    logic idle_full;
    assign idle_full = idle == IDLE_W'(TIMEOUT);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idle        <= '0;
            signal_lost <= 1'b1;
        end else begin
            idle        <= rise ? '0 : (tick_wrap && !idle_full) ? idle + IDLE_W'(1) : idle;
            signal_lost <= valid_nx ? 1'b0 : idle_full ? 1'b1 : signal_lost;
        end
`else
    // No idle counter in this build; TIMEOUT has no effect.
    assign signal_lost = 1'b0 && (TIMEOUT > 0);
`endif
endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb_servo_pulse_decoder: directed table plus corner sequences for servo_pulse_decoder
module tb_servo_pulse_decoder;
    localparam int DIV     = 8;
    localparam int TIMEOUT = 700;
`ifdef SERVO_DEC_TIMEOUT_EN
    localparam logic LOST_EN = 1'b1;
`else
    localparam logic LOST_EN = 1'b0;
`endif

    typedef struct {
        int         hi;
        logic       ev;
        logic       ee;
        logic [7:0] ep;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1, pwm_in = 1'b0;
    logic [7:0] pos;
    logic       pos_valid, pos_err, signal_lost;
    int         n_cmp = 0, n_bad = 0;
    int         n_valid = 0, n_err = 0;
    logic       overlap = 1'b0, lost_seen = 1'b0;
    vec_t       vecs[12];

    always #5 clk = ~clk;

    servo_pulse_decoder #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .pos(pos),
        .pos_valid(pos_valid), .pos_err(pos_err), .signal_lost(signal_lost)
    );

    always @(posedge clk) begin
        if (pos_valid) n_valid++;
        if (pos_err) n_err++;
        if (pos_valid && pos_err) overlap = 1'b1;
        if (signal_lost) lost_seen = 1'b1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge: pin high for hi clocks, then low; strobe must appear at the 3rd negedge.
    task automatic run_pulse(input string tag, input int hi, input logic ev, input logic ee,
                             input logic [7:0] ep);
        int v0, e0, stray;
        logic v3, e3;
        v0 = n_valid; e0 = n_err; stray = 0; v3 = 1'b0; e3 = 1'b0;
        pwm_in = 1'b1;
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) begin
                v3 = pos_valid;
                e3 = pos_err;
            end else if (pos_valid || pos_err) stray++;
        end
        repeat (4) @(negedge clk);
        check({tag, " valid@3"}, v3, ev);
        check({tag, " err@3"}, e3, ee);
        check({tag, " pos"}, pos, ep);
        check({tag, " stray"}, stray, 0);
        check({tag, " nvalid"}, n_valid - v0, ev);
        check({tag, " nerr"}, n_err - e0, ee);
    endtask

    initial begin
        int v0, e0;
        vecs[0]  = '{256*DIV,     1'b1, 1'b0, 8'd0};
        vecs[1]  = '{383*DIV,     1'b1, 1'b0, 8'd127};
        vecs[2]  = '{511*DIV,     1'b1, 1'b0, 8'd255};
        vecs[3]  = '{255*DIV,     1'b0, 1'b1, 8'd255};
        vecs[4]  = '{300*DIV + 3, 1'b1, 1'b0, 8'd44};
        vecs[5]  = '{300*DIV - 3, 1'b1, 1'b0, 8'd44};
        vecs[6]  = '{256*DIV - 3, 1'b1, 1'b0, 8'd0};
        vecs[7]  = '{256*DIV - 5, 1'b0, 1'b1, 8'd0};
        vecs[8]  = '{511*DIV + 3, 1'b1, 1'b0, 8'd255};
        vecs[9]  = '{511*DIV + 5, 1'b0, 1'b1, 8'd255};
        vecs[10] = '{10,          1'b0, 1'b1, 8'd255};
        vecs[11] = '{257*DIV + 1, 1'b1, 1'b0, 8'd1};

        repeat (3) @(negedge clk);
        check("reset pos", pos, 0);
        check("reset valid", pos_valid, 0);
        check("reset err", pos_err, 0);
        check("reset lost", signal_lost, LOST_EN);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        run_pulse("first", 256*DIV, 1'b1, 1'b0, 8'd0);
        check("lost cleared", signal_lost, 0);

        foreach (vecs[i])
            run_pulse($sformatf("vec%0d", i), vecs[i].hi, vecs[i].ev, vecs[i].ee, vecs[i].ep);
        check("lost after table", signal_lost, 0);

        // held high 600 ticks: one error when ticks hit 512, nothing on the late fall
        v0 = n_valid; e0 = n_err;
        pwm_in = 1'b1;
        repeat (512*DIV - 4) @(negedge clk);
        check("hold err early", n_err - e0, 0);
        repeat (12) @(negedge clk);
        check("hold err at 512", n_err - e0, 1);
        repeat (88*DIV - 8) @(negedge clk);
        pwm_in = 1'b0;
        repeat (12) @(negedge clk);
        check("hold err total", n_err - e0, 1);
        check("hold valid", n_valid - v0, 0);
        check("hold pos", pos, 1);
        run_pulse("after hold", 383*DIV, 1'b1, 1'b0, 8'd127);

        // loopback-style generator at pos 250
        v0 = n_valid; e0 = n_err;
        for (int p = 0; p < 2; p++) begin
            pwm_in = 1'b1;
            repeat (506*DIV) @(negedge clk);
            pwm_in = 1'b0;
            repeat (100) @(negedge clk);
        end
        check("loop nvalid", n_valid - v0, 2);
        check("loop nerr", n_err - e0, 0);
        check("loop pos", pos, 250);

        // reset mid-pulse, pin still high at release: partial pulse discarded
        pwm_in = 1'b1;
        repeat (1000) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst pos", pos, 0);
        check("midrst valid", pos_valid, 0);
        check("midrst err", pos_err, 0);
        check("midrst lost", signal_lost, LOST_EN);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v0 = n_valid; e0 = n_err;
        repeat (100) @(negedge clk);
        pwm_in = 1'b0;
        repeat (12) @(negedge clk);
        check("partial nvalid", n_valid - v0, 0);
        check("partial nerr", n_err - e0, 0);
        run_pulse("post reset", 300*DIV, 1'b1, 1'b0, 8'd44);
        check("post reset lost", signal_lost, 0);

        // idle timeout measured from the last rising edge
        run_pulse("pre idle", 256*DIV, 1'b1, 1'b0, 8'd0);
        repeat (400*DIV) @(negedge clk);
        check("idle early lost", signal_lost, 0);
        repeat (100*DIV) @(negedge clk);
        check("idle lost", signal_lost, LOST_EN);

        check("valid/err overlap", overlap, 0);
        check("lost ever seen", lost_seen, LOST_EN);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/servo_pulse_decoder.md
# servo_pulse_decoder

Receive-side counterpart of the servo PWM generator. Measures the high time of an incoming hobby-servo pulse train on a single pin and recovers the 8-bit position that produced it. The encoding matches our generator: high time = (256 + pos) ticks, with tick = DIV system clocks, giving 1.0–2.0 ms at 12 MHz. Sits between an input pin (RC receiver, or our own generator in loopback) and any logic that consumes a servo position.

## Interface
- DIV, 47: system clocks per tick; must be ≥ 4.
- TIMEOUT, 8192: ticks without a rising edge before signal_lost asserts.
- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pwm_in  in  1  asynchronous servo pulse input.
- pos  out  8  last valid decoded position; holds between updates.
- pos_valid  out  1  one-cycle strobe when pos is updated.
- pos_err  out  1  one-cycle strobe when a pulse is out of range.
- signal_lost  out  1  level; no pulse seen for TIMEOUT ticks.

## Operation
- pwm_in passes through a 2-flop synchronizer; edges are detected on the synchronized signal (q2 vs. registered q3).
- sub counter (0..DIV-1) and tick counter (10 bits, saturating at 512) both restart on every detected rising edge. Tick counter increments when sub wraps.
- FSM states:
  - WAIT_LOW (reset state): ignore input until the synchronized signal is low, then go to WAIT_RISE. Discards a partial pulse present at reset release.
  - WAIT_RISE: on rising edge, clear counters and go to MEASURE.
  - MEASURE, on falling edge: width = ticks + (sub ≥ DIV/2), rounding to the nearest tick.
    - If 256 ≤ width ≤ 511: pos ← width − 256, pulse pos_valid, go to WAIT_RISE.
    - Otherwise: pulse pos_err, go to WAIT_RISE.
  - MEASURE, when ticks reaches 512 while still high: pulse pos_err, go to WAIT_FALL.
  - WAIT_FALL: on falling edge, go to WAIT_RISE. No second strobe is issued.
- Width arithmetic is unsigned, 10 bits. pos is the low 8 bits of width − 256.
- pos_valid and pos_err are never high in the same cycle.
- Reset values: pos = 0, pos_valid = 0, pos_err = 0. signal_lost resets to 1 with the timeout feature compiled in, 0 without.
- Reset asserted mid-pulse: outputs go to their reset values immediately and the FSM returns to WAIT_LOW.

## Timing
- Latency: pos_valid / pos_err rise on the 3rd clk edge after the first edge that samples pwm_in low. Sync adds 2 edges, decision register adds 1.
- Rising-edge latency is identical, so measured width equals the true width exactly for whole-clock pulses.
- A pulse of exactly (256 + p)·DIV clocks decodes to p.
- Width tolerance: ±(DIV/2 − 1) clocks around a tick multiple still decodes to the same p.
- Minimum low time between pulses: 2 clocks. Shorter gaps are sampled as continuous high.

## Configuration
- SERVO_DEC_TIMEOUT_EN defined:
  - A tick-based idle counter runs in all states and clears on each rising edge.
  - signal_lost sets when the counter reaches TIMEOUT.
  - signal_lost clears on the same cycle as the next pos_valid.
- SERVO_DEC_TIMEOUT_EN undefined: idle counter is absent, signal_lost is tied 0, and the TIMEOUT parameter is ignored.

## Structure
- Shared package servo_pkg holds:
  - PULSE_BASE = 256
  - PULSE_MAX = 511
  - POS_W = 8
  - default DIV = 47
  - the FSM state typedef (WAIT_LOW, WAIT_RISE, MEASURE, WAIT_FALL).
- The generator uses the same constants from servo_pkg.
- One sub-module, servo_sync: a 2-flop synchronizer plus rise/fall edge detect. It resets to low and is reusable for other pin inputs.

## Test plan
- Loopback against our generator at pos = 250, DIV = 47 -> one pos_valid per period with pos = 250; no pos_err.
- Direct pulses of 256·47, 383·47 and 511·47 clocks -> pos = 0, 127, 255 respectively; pos_valid 3 clocks after each fall.
- Pulse of 255·47 clocks -> pos_err strobe; pos holds its previous value.
- pwm_in held high for 600 ticks -> single pos_err at tick 512; no further strobe on the later fall.
- pwm_in high at reset release, then a valid 300-tick pulse -> first partial pulse ignored, second gives pos = 44.
- With SERVO_DEC_TIMEOUT_EN: signal_lost = 1 after reset; clears with the first valid pulse; pwm_in then held low for 8192 ticks -> signal_lost = 1. Without the macro, signal_lost stays 0 throughout.
